// File: rtl/arb_pkg.sv
// Shared definitions for the 3-master memory arbitration protocol.
// Master indices, accmodule grant codes and requester FSM states.
package arb_pkg;

  localparam int M1 = 0;
  localparam int M2 = 1;
  localparam int M3 = 2;

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_M1   = 2'd1;
  localparam logic [1:0] ACC_M2   = 2'd2;
  localparam logic [1:0] ACC_M3   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACTIVE
  } req_state_e;

  function automatic logic [1:0] acc_code(int id);
    case (id)
      1:       acc_code = ACC_M1;
      2:       acc_code = ACC_M2;
      3:       acc_code = ACC_M3;
      default: acc_code = ACC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_requester_if.sv
// Requester bus: client command channel plus arbiter req/done/grant.
// master = requester side, slave = client/arbiter side.
interface mem_requester_if #(
  parameter int LEN_W = 8
);

  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic [1:0]       accmodule;
  logic             req;
  logic             done;

  modport master (
    input  cmd_valid,
    input  cmd_len,
    input  accmodule,
    output cmd_ready,
    output req,
    output done
  );

  modport slave (
    output cmd_valid,
    output cmd_len,
    output accmodule,
    input  cmd_ready,
    input  req,
    input  done
  );

endinterface

// File: rtl/cmd_fifo.sv
// Command FIFO: registered storage, same-cycle push/pop.
// Ports: push/pop/din in; head/full/empty out.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB tells full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/mem_requester.sv
// Master-side requester: queues N-beat commands, drives req/done,
// tracks grants, re-requests after preemption, counts interrupts.
module mem_requester
  import arb_pkg::*;
#(
  parameter int MASTER_ID = 1,
  parameter int LEN_W     = 8,
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_requester_if.master  bus,
  output logic             beat,
  output logic             cmd_complete,
  output logic             busy,
  output logic [CNT_W-1:0] nb_interrupts
);

  localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  req_state_e       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       burst_q, burst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant;
  logic             pop;
  logic             empty;
  logic             full;
  logic [LEN_W-1:0] head;
  logic             one_left;
  logic             req_c;
  logic             done_c;

  cmd_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (bus.cmd_valid),
    .pop   (pop),
    .din   (bus.cmd_len),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign grant    = (bus.accmodule == acc_code(MASTER_ID));
  assign one_left = (rem_q == REM_ONE);

  assign bus.cmd_ready = !full;
  assign bus.req       = req_c;
  assign bus.done      = done_c;
  assign busy          = (state_q != IDLE) || !empty;
  assign nb_interrupts = cnt_q;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    burst_d      = burst_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    beat         = 1'b0;
    done_c       = 1'b0;
    cmd_complete = 1'b0;
    req_c        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // zero-length commands are discarded here
          if (head != '0) begin
            rem_d   = head;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req_c = 1'b1;
        if (grant) begin
          beat    = 1'b1;
          rem_d   = rem_q - REM_ONE;
          burst_d = 2'd1;
          state_d = ACTIVE;
          if (one_left) begin
            done_c       = 1'b1;
            cmd_complete = 1'b1;
          end
        end
      end
      ACTIVE: begin
        req_c = 1'b1;
        if (grant) begin
          beat    = 1'b1;
          rem_d   = rem_q - REM_ONE;
          burst_d = (burst_q == 2'd2) ? 2'd2 : burst_q + 2'd1;
          if (one_left) begin
            done_c       = 1'b1;
            cmd_complete = 1'b1;
            if (empty) begin
              req_c = 1'b0;
            end
          end
        end else if (rem_q != '0) begin
          state_d = REQ;
          // single-beat grant cut short: slot went to M1
          if (MASTER_ID != 1 && burst_q == 2'd1 &&
              cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // last beat: chain straight into the next queued command
    if (cmd_complete) begin
      if (!empty) begin
        pop = 1'b1;
        if (head != '0) begin
          rem_d   = head;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Bench: three requesters (M1/M2/M3) on one shared grant bus,
// per-instance scoreboard of command lengths checked on beats.
module tb_mem_requester;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] acc = ACC_NONE;

  always #5 clk = ~clk;

  mem_requester_if #(.LEN_W(8)) if1 ();
  mem_requester_if #(.LEN_W(8)) if2 ();
  mem_requester_if #(.LEN_W(8)) if3 ();

  assign if1.accmodule = acc;
  assign if2.accmodule = acc;
  assign if3.accmodule = acc;

  logic        beat_w [3];
  logic        cc_w   [3];
  logic        busy_w [3];
  logic [15:0] nb_w   [3];

  mem_requester #(.MASTER_ID(1)) u_m1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (if1.master),
    .beat          (beat_w[0]),
    .cmd_complete  (cc_w[0]),
    .busy          (busy_w[0]),
    .nb_interrupts (nb_w[0])
  );

  mem_requester #(.MASTER_ID(2)) u_m2 (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (if2.master),
    .beat          (beat_w[1]),
    .cmd_complete  (cc_w[1]),
    .busy          (busy_w[1]),
    .nb_interrupts (nb_w[1])
  );

  mem_requester #(.MASTER_ID(3)) u_m3 (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (if3.master),
    .beat          (beat_w[2]),
    .cmd_complete  (cc_w[2]),
    .busy          (busy_w[2]),
    .nb_interrupts (nb_w[2])
  );

  int total = 0;
  int bad   = 0;
  int exp_q [3][$];
  int cnt   [3];
  int beats [3];
  int ccs   [3];
  bit mon_last;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(int i, logic v, logic [7:0] len);
    case (i)
      0: begin if1.cmd_valid = v; if1.cmd_len = len; end
      1: begin if2.cmd_valid = v; if2.cmd_len = len; end
      default: begin if3.cmd_valid = v; if3.cmd_len = len; end
    endcase
  endtask

  function automatic logic get_req(int i);
    case (i)
      0:       return if1.req;
      1:       return if2.req;
      default: return if3.req;
    endcase
  endfunction

  function automatic logic get_done(int i);
    case (i)
      0:       return if1.done;
      1:       return if2.done;
      default: return if3.done;
    endcase
  endfunction

  function automatic logic get_ready(int i);
    case (i)
      0:       return if1.cmd_ready;
      1:       return if2.cmd_ready;
      default: return if3.cmd_ready;
    endcase
  endfunction

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int i, int len);
    logic rdy;
    rdy = get_ready(i);
    set_cmd(i, 1'b1, len[7:0]);
    step();
    set_cmd(i, 1'b0, 8'd0);
    if (rdy && len != 0) exp_q[i].push_back(len);
  endtask

  task automatic wait_idle(int i, int lim);
    int n;
    n = 0;
    while (busy_w[i] && n < lim) begin
      step();
      n++;
    end
    chk($sformatf("idle_to%0d", i + 1), busy_w[i], 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_q[i].delete();
        cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (beat_w[i]) begin
          beats[i]++;
          if (exp_q[i].size() == 0) begin
            chk($sformatf("beat_unexp%0d", i + 1), 1, 0);
          end else begin
            cnt[i]++;
            mon_last = (cnt[i] == exp_q[i][0]);
            chk($sformatf("done%0d", i + 1),
                get_done(i), mon_last);
            chk($sformatf("cmpl%0d", i + 1),
                cc_w[i], mon_last);
            if (mon_last) begin
              void'(exp_q[i].pop_front());
              cnt[i] = 0;
            end
          end
        end else begin
          chk($sformatf("idle_dc%0d", i + 1),
              {get_done(i), cc_w[i]}, 0);
        end
        if (cc_w[i]) ccs[i]++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      set_cmd(i, 1'b0, 8'd0);
      cnt[i]   = 0;
      beats[i] = 0;
      ccs[i]   = 0;
    end

    // reset values
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rdy", get_ready(i), 1'b1);
      chk("rst_req", get_req(i), 1'b0);
      chk("rst_done", get_done(i), 1'b0);
      chk("rst_beat", beat_w[i], 1'b0);
      chk("rst_busy", busy_w[i], 1'b0);
      chk("rst_nb", nb_w[i], 0);
    end
    reset_n = 1'b1;
    step();

    // M1, len=3, grant held
    push(0, 3);
    step();
    chk("t2_req0", get_req(0), 1'b1);
    acc = ACC_M1;
    step();
    chk("t2_req1", get_req(0), 1'b1);
    chk("t2_nodone", get_done(0), 1'b0);
    step();
    chk("t2_done", get_done(0), 1'b1);
    chk("t2_reqlow", get_req(0), 1'b0);
    step();
    acc = ACC_NONE;
    chk("t2_beats", beats[0], 3);
    chk("t2_cc", ccs[0], 1);
    chk("t2_busy", busy_w[0], 1'b0);

    // M2, len=5, grants 2/2/1
    push(1, 5);
    step();
    acc = ACC_M2;
    step(2);
    acc = ACC_NONE;
    #1;
    chk("t3_gap1", get_req(1), 1'b1);
    step();
    chk("t3_rereq1", get_req(1), 1'b1);
    acc = ACC_M2;
    step(2);
    acc = ACC_NONE;
    #1;
    chk("t3_gap2", get_req(1), 1'b1);
    chk("t3_gapdone", get_done(1), 1'b0);
    step();
    chk("t3_rereq2", get_req(1), 1'b1);
    acc = ACC_M2;
    step();
    acc = ACC_NONE;
    chk("t3_nb", nb_w[1], 0);
    chk("t3_beats", beats[1], 5);
    chk("t3_cc", ccs[1], 1);

    // M3, len=4, preempted by M1 after one beat
    push(2, 4);
    step();
    acc = ACC_M3;
    step();
    acc = ACC_M1;
    step();
    chk("t4_nb", nb_w[2], 1);
    chk("t4_req", get_req(2), 1'b1);
    chk("t4_m1nb", nb_w[0], 0);
    acc = ACC_M3;
    step(2);
    chk("t4_done", get_done(2), 1'b1);
    chk("t4_reqlow", get_req(2), 1'b0);
    step();
    acc = ACC_NONE;
    chk("t4_nb2", nb_w[2], 1);
    chk("t4_beats", beats[2], 4);
    chk("t4_cc", ccs[2], 1);

    // back-to-back len=1 then len=2
    push(2, 1);
    push(2, 2);
    acc = ACC_M3;
    #1;
    chk("t5_req_d1", get_req(2), 1'b1);
    chk("t5_done1", get_done(2), 1'b1);
    step();
    chk("t5_req2", get_req(2), 1'b1);
    step();
    chk("t5_done2", get_done(2), 1'b1);
    chk("t5_reqlow", get_req(2), 1'b0);
    step();
    acc = ACC_NONE;
    chk("t5_beats", beats[2], 7);
    chk("t5_cc", ccs[2], 3);

    // reset mid-access (remaining=3)
    push(2, 4);
    step();
    acc = ACC_M3;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1_req", get_req(2), 1'b0);
    chk("t1_done", get_done(2), 1'b0);
    chk("t1_beat", beat_w[2], 1'b0);
    chk("t1_busy", busy_w[2], 1'b0);
    chk("t1_nb", nb_w[2], 0);
    chk("t1_rdy", get_ready(2), 1'b1);
    acc = ACC_NONE;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // zero-length command is dropped
    push(0, 0);
    chk("t6_zbusy", busy_w[0], 1'b1);
    chk("t6_zreq0", get_req(0), 1'b0);
    step();
    chk("t6_zreq1", get_req(0), 1'b0);
    chk("t6_zidle", busy_w[0], 1'b0);

    // fill the FIFO with no grant
    push(1, 2);
    push(1, 0);
    push(1, 1);
    chk("t6_rdy_mid", get_ready(1), 1'b1);
    push(1, 1);
    push(1, 1);
    chk("t6_full", get_ready(1), 1'b0);
    push(1, 3);
    chk("t6_full2", get_ready(1), 1'b0);
    acc = ACC_M2;
    wait_idle(1, 40);
    acc = ACC_NONE;
    chk("t6_beats", beats[1], 10);
    chk("t6_cc", ccs[1], 5);
    step(2);

    for (int i = 0; i < 3; i++) begin
      chk("sb_empty", exp_q[i].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
